// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - shared IO-space map and timer definitions
//
// Purpose: timer base address, register offsets within the timer window,
// CTRL bit positions and the timer state encoding.
// Ports: none (package).
package io_map_pkg;

    localparam logic [7:0] TIMER_BASE = 8'hC0;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit indices
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_PRE_LSB = 8;
    localparam int CTRL_PRE_MSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - 8-bit prescaler producing one tick every pre+1 clocks
//
// Purpose: counts enabled clocks; tick is high in the cycle where the count
// equals pre, and the count then returns to 0.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   clear          force count to 0 (dominates enable)
//   enable         advance the count this clock
//   pre            terminal value of the count
//   tick           combinational: enable && count == pre
module timer_prescaler (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] pre,
    output logic       tick
);

    logic [7:0] count;

    assign tick = enable && (count == pre);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear || tick) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/io_timer_responder.sv
// rtl/io_timer_responder.sv - memory-mapped countdown timer on the IO bus
//
// Purpose: CTRL/LOAD/COUNT/STATUS registers in the IO window at BASE_ADDR,
// countdown FSM with prescaler, optional auto-reload and expiry interrupt.
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   addr               CPU byte address, bits [7:2] used
//   datain             CPU store data
//   write_io_enable    IO-space write strobe
//   io_read_data       combinational readback, 0 when not selected
//   timer_sel          address falls within this block's 16-byte window
//   timer_irq          expired & irq_en
module io_timer_responder
    import io_map_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = TIMER_BASE,
    parameter int         CNT_W     = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        write_io_enable,
    output logic [31:0] io_read_data,
    output logic        timer_sel,
    output logic        timer_irq
);

    timer_state_t     state;
    logic             ctrl_en;
    logic             ctrl_auto;
    logic             ctrl_irq_en;
    logic [7:0]       ctrl_pre;
    logic [CNT_W-1:0] load;
    logic [CNT_W-1:0] count;
    logic             expired;

    logic [1:0]       offset;
    logic             wr;
    logic             wr_ctrl;
    logic             wr_en;
    logic             tick;

    wire unused_addr = &{1'b0, addr[31:8], addr[1:0]};

    assign offset    = addr[3:2];
    assign timer_sel = (addr[7:4] == BASE_ADDR[7:4]);
    assign wr        = write_io_enable && timer_sel;
    assign wr_ctrl   = wr && (offset == REG_CTRL);
    assign wr_en     = datain[CTRL_EN];
    assign timer_irq = expired && ctrl_irq_en;

    // Any enabling CTRL write (start or restart) realigns the prescaler.
    timer_prescaler u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (wr_ctrl && wr_en),
        .enable (state == ST_RUN),
        .pre    (ctrl_pre),
        .tick   (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_pre    <= 8'd0;
            load        <= '0;
            count       <= '0;
            expired     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= datain[CTRL_EN];
                ctrl_auto   <= datain[CTRL_AUTO];
                ctrl_irq_en <= datain[CTRL_IRQ_EN];
                ctrl_pre    <= datain[CTRL_PRE_MSB:CTRL_PRE_LSB];
            end
            if (wr && (offset == REG_LOAD)) begin
                load <= datain[CNT_W-1:0];
            end
            // Clear first so a same-edge expiry below overrides it.
            if (wr && (offset == REG_STATUS) && datain[0]) begin
                expired <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (wr_ctrl) begin
                        if (wr_en) begin
                            state <= ST_RUN;
                            count <= load;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (count != '0) begin
                            count <= count - 1'b1;
                        end else begin
                            expired <= 1'b1;
                            if (ctrl_auto) begin
                                count <= load;
                            end else begin
                                state <= ST_DONE;
                                // A concurrent CTRL write owns the en bit.
                                if (!wr_ctrl) begin
                                    ctrl_en <= 1'b0;
                                end
                            end
                        end
                    end
                    // CTRL writes take precedence over the tick's count/state update.
                    if (wr_ctrl) begin
                        if (wr_en) begin
                            state <= ST_RUN;
                            count <= load;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        io_read_data = 32'd0;
        if (timer_sel) begin
            case (offset)
                REG_CTRL:   io_read_data = {16'd0, ctrl_pre, 5'd0,
                                            ctrl_irq_en, ctrl_auto, ctrl_en};
                REG_LOAD:   io_read_data = 32'(load);
                REG_COUNT:  io_read_data = 32'(count);
                REG_STATUS: io_read_data = {31'd0, expired};
                default:    io_read_data = 32'd0;
            endcase
        end
    end

endmodule
